// File: rtl/data_bus_responder.sv
// Data-port responder: word-addressed data RAM plus one memory-mapped countdown timer.
// Define BUS_WRITE_LOG_EN to print every accepted write. Leave it undefined for synthesis.
module data_bus_responder #(
    parameter int          DM_WORDS   = 3072,
    parameter logic [31:0] DM_BASE    = 32'h0000_0000,
    parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] m_data_addr,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_wdata,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        timer_irq,
    output logic [1:0]  o_dbg_state
);

    localparam int          DM_AW    = $clog2(DM_WORDS);
    localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_PRESET = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;

    logic [31:0]      r_dm [DM_WORDS];
    logic [1:0]       r_state;
    logic [3:0]       r_ctrl;
    logic [31:0]      r_preset;
    logic [31:0]      r_count;
    logic             r_pend;

    logic [32:0]      w_dm_off;
    logic             w_dm_hit;
    logic [DM_AW-1:0] w_dm_idx;
    logic [31:0]      w_dm_old;
    logic [31:0]      w_dm_merged;
    logic             w_dm_we;
    logic             w_tmr_hit;
    logic [1:0]       w_tmr_sel;
    logic             w_tmr_we;
    logic             w_wr_ctrl;
    logic             w_wr_preset;
    logic             w_one_shot;

    // 33-bit subtraction keeps the lower-bound test meaningful for any DM_BASE.
    assign w_dm_off  = {1'b0, m_data_addr} - {1'b0, DM_BASE};
    assign w_dm_hit  = !w_dm_off[32] && (w_dm_off[31:0] < DM_BYTES);
    assign w_dm_idx  = w_dm_off[DM_AW+1:2];
    assign w_dm_old  = r_dm[w_dm_idx];
    assign w_dm_we   = w_dm_hit && (m_data_byteen != 4'b0000);

    assign w_tmr_sel   = m_data_addr[3:2];
    assign w_tmr_hit   = !w_dm_hit && (m_data_addr[31:4] == TIMER_BASE[31:4])
                         && (w_tmr_sel != 2'b11);
    assign w_tmr_we    = w_tmr_hit && (m_data_byteen == 4'b1111) && (w_tmr_sel != SEL_COUNT);
    assign w_wr_ctrl   = w_tmr_we && (w_tmr_sel == SEL_CTRL);
    assign w_wr_preset = w_tmr_we && (w_tmr_sel == SEL_PRESET);
    assign w_one_shot  = (r_ctrl[2:1] != 2'b01);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_dm_merged[8*i +: 8] = m_data_byteen[i] ? m_data_wdata[8*i +: 8] : w_dm_old[8*i +: 8];
        end
    end

    always_comb begin
        m_data_rdata = 32'h0;
        if (w_dm_hit) begin
            m_data_rdata = w_dm_old;
        end else if (w_tmr_hit) begin
            case (w_tmr_sel)
                SEL_CTRL:   m_data_rdata = {28'h0, r_ctrl};
                SEL_PRESET: m_data_rdata = r_preset;
                SEL_COUNT:  m_data_rdata = r_count;
                default:    m_data_rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                r_dm[i] <= 32'h0;
            end
        end else if (w_dm_we) begin
            r_dm[w_dm_idx] <= w_dm_merged;
        end
    end

    // A CPU CTRL write is applied last so it overrides whatever the FSM did this cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_ctrl   <= 4'h0;
            r_preset <= 32'h0;
            r_count  <= 32'h0;
            r_pend   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_ctrl[0]) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_count <= r_preset;
                    r_state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!r_ctrl[0]) begin
                        r_state <= ST_IDLE;
                    end else if (r_count == 32'h0) begin
                        r_pend  <= 1'b1;
                        r_state <= ST_INT;
                    end else begin
                        r_count <= r_count - 32'h1;
                    end
                end
                default: begin
                    if (w_one_shot) r_ctrl[0] <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_wr_preset) begin
                r_preset <= m_data_wdata;
            end
            if (w_wr_ctrl) begin
                r_ctrl  <= m_data_wdata[3:0];
                r_pend  <= 1'b0;
                r_state <= ST_IDLE;
            end
        end
    end

    assign timer_irq   = r_pend & r_ctrl[3];
    assign o_dbg_state = r_state;

`ifdef BUS_WRITE_LOG_EN
    always_ff @(posedge Clk) begin
        if (!Reset && (w_dm_we || w_tmr_we)) begin
            $display("%d@%h: *%h <= %h", $time, m_inst_addr, {m_data_addr[31:2], 2'b00},
                     w_dm_hit ? w_dm_merged : m_data_wdata);
        end
    end
`else
    logic w_unused;
    assign w_unused = ^m_inst_addr;
`endif

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: RAM lane merging, decode, and timer FSM timing.
module tb_data_bus_responder;

    localparam logic [31:0] T_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] T_PRESET = 32'h0000_7F04;
    localparam logic [31:0] T_COUNT  = 32'h0000_7F08;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] m_data_addr = 32'h0;
    logic [3:0]  m_data_byteen = 4'h0;
    logic [31:0] m_data_wdata = 32'h0;
    logic [31:0] m_inst_addr = 32'h0000_3000;
    logic [31:0] m_data_rdata;
    logic        timer_irq;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;

    data_bus_responder dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .m_data_addr   (m_data_addr),
        .m_data_byteen (m_data_byteen),
        .m_data_wdata  (m_data_wdata),
        .m_inst_addr   (m_inst_addr),
        .m_data_rdata  (m_data_rdata),
        .timer_irq     (timer_irq),
        .o_dbg_state   (o_dbg_state)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
        m_data_addr   = addr;
        m_data_byteen = be;
        m_data_wdata  = data;
        m_inst_addr   = m_inst_addr + 32'h4;
        tick();
        m_data_byteen = 4'h0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        m_data_addr   = addr;
        m_data_byteen = 4'h0;
        #1;
        chk(tag, m_data_rdata, exp);
    endtask

    task automatic chk_tmr(input string tag, input logic [1:0] st, input logic irq);
        chk({tag, "_state"}, {30'h0, o_dbg_state}, {30'h0, st});
        chk({tag, "_irq"}, {31'h0, timer_irq}, {31'h0, irq});
    endtask

    initial begin
        // Reset
        tick();
        tick();
        Reset = 1'b0;
        rd(32'h10, 32'h0, "rst_dm10");
        rd(T_CTRL, 32'h0, "rst_ctrl");
        rd(T_PRESET, 32'h0, "rst_preset");
        rd(T_COUNT, 32'h0, "rst_count");
        chk_tmr("rst", 2'd0, 1'b0);

        // RAM word and byte-lane writes
        wr(32'h10, 4'hF, 32'h1234_5678);
        rd(32'h10, 32'h1234_5678, "sw_rd");
        wr(32'h10, 4'b0100, 32'h00AB_0000);
        rd(32'h10, 32'h12AB_5678, "sb_merge");
        wr(32'h11, 4'b0001, 32'h0000_00EE);
        rd(32'h10, 32'h12AB_56EE, "addr_lsb_ignored");

        // Same-cycle read sees the old word, next cycle sees the new one
        m_data_addr   = 32'h14;
        m_data_byteen = 4'hF;
        m_data_wdata  = 32'hDEAD_BEEF;
        #1;
        chk("same_cycle_old", m_data_rdata, 32'h0);
        tick();
        m_data_byteen = 4'h0;
        rd(32'h14, 32'hDEAD_BEEF, "raw_next_cycle");

        // Window edges and unmapped space
        wr(32'h2FFC, 4'hF, 32'hCAFE_F00D);
        rd(32'h2FFC, 32'hCAFE_F00D, "dm_last_word");
        rd(32'h3000, 32'h0, "unmapped_3000");
        rd(32'h7F0C, 32'h0, "unmapped_7f0c");
        wr(32'h3000, 4'hF, 32'hFFFF_FFFF);
        rd(32'h3000, 32'h0, "unmapped_wr_3000");
        rd(32'h0, 32'h0, "dm0_untouched");
        rd(32'h2FFC, 32'hCAFE_F00D, "dm_last_untouched");

        // One-shot: PRESET=3, CTRL=EN|IM
        wr(T_PRESET, 4'hF, 32'd3);
        rd(T_PRESET, 32'd3, "preset_rd");
        wr(T_CTRL, 4'hF, 32'h9);
        chk_tmr("os_e0", 2'd0, 1'b0);
        tick();
        chk_tmr("os_e1", 2'd1, 1'b0);
        tick();
        rd(T_COUNT, 32'd3, "os_cnt3");
        tick();
        rd(T_COUNT, 32'd2, "os_cnt2");
        tick();
        rd(T_COUNT, 32'd1, "os_cnt1");
        tick();
        rd(T_COUNT, 32'd0, "os_cnt0");
        chk_tmr("os_e5", 2'd2, 1'b0);
        tick();
        chk_tmr("os_e6", 2'd3, 1'b1);
        tick();
        chk_tmr("os_e7", 2'd0, 1'b1);
        rd(T_CTRL, 32'h8, "os_en_cleared");
        tick();
        tick();
        chk_tmr("os_hold", 2'd0, 1'b1);
        wr(T_COUNT, 4'hF, 32'h55);
        rd(T_COUNT, 32'h0, "count_ro");
        wr(T_CTRL, 4'hF, 32'hFFFF_FFF0);
        rd(T_CTRL, 32'h0, "ctrl_upper_zero");
        chk("irq_cleared", {31'h0, timer_irq}, 32'h0);

        // Partial writes to the timer are dropped
        wr(T_PRESET, 4'b0011, 32'h0000_FFFF);
        rd(T_PRESET, 32'd3, "preset_partial_drop");

        // Auto-reload with IM=0
        wr(T_PRESET, 4'hF, 32'd2);
        wr(T_CTRL, 4'hF, 32'h3);
        tick();
        tick();
        rd(T_COUNT, 32'd2, "ar_cnt2");
        tick();
        tick();
        rd(T_COUNT, 32'd0, "ar_cnt0");
        tick();
        chk_tmr("ar_int", 2'd3, 1'b0);
        tick();
        chk_tmr("ar_idle", 2'd0, 1'b0);
        rd(T_CTRL, 32'h3, "ar_en_kept");
        tick();
        chk_tmr("ar_load", 2'd1, 1'b0);
        tick();
        rd(T_COUNT, 32'd2, "ar_reload");
        chk_tmr("ar_cnt", 2'd2, 1'b0);
        wr(T_CTRL, 4'hF, 32'h0);

        // CTRL write lands in the INT cycle of a one-shot run
        wr(T_PRESET, 4'hF, 32'd1);
        wr(T_CTRL, 4'hF, 32'h9);
        tick();
        tick();
        tick();
        tick();
        chk_tmr("race_int", 2'd3, 1'b1);
        wr(T_CTRL, 4'hF, 32'hD);
        rd(T_CTRL, 32'hD, "race_ctrl_wins");
        chk_tmr("race_after", 2'd0, 1'b0);
        wr(T_CTRL, 4'hF, 32'h0);

        // Reset in the middle of a count
        wr(T_PRESET, 4'hF, 32'd10);
        wr(T_CTRL, 4'hF, 32'h9);
        for (int i = 0; i < 7; i++) tick();
        rd(T_COUNT, 32'd5, "mid_cnt5");
        chk_tmr("mid", 2'd2, 1'b0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        rd(T_COUNT, 32'h0, "mrst_count");
        rd(T_CTRL, 32'h0, "mrst_ctrl");
        rd(T_PRESET, 32'h0, "mrst_preset");
        rd(32'h10, 32'h0, "mrst_dm10");
        chk_tmr("mrst", 2'd0, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        chk_tmr("mrst_quiet", 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
